// File: rtl/vdcm_ssm_word_dispatch_if.sv
// Source and substream-parser handshake bundle for the SSM word dispatcher.
// master = source + parsers side, slave = dispatcher side.
interface vdcm_ssm_word_dispatch_if #(
    parameter int NUM_SSM = 4,
    parameter int DATA_W  = 128
);
    logic                      in_valid;
    logic [DATA_W-1:0]         in_data;
    logic                      in_ready;
    logic [NUM_SSM-1:0]        rd_en;
    logic [NUM_SSM-1:0]        rd_ack;
    logic [NUM_SSM*DATA_W-1:0] rd_data;

    modport master (
        output in_valid, in_data, rd_en,
        input  in_ready, rd_ack, rd_data
    );

    modport slave (
        input  in_valid, in_data, rd_en,
        output in_ready, rd_ack, rd_data
    );
endinterface

// File: rtl/vdcm_ssm_word_dispatch.sv
// Circular word FIFO that hands consecutive codec words to every requesting
// substream parser in the same cycle, lowest channel index first.
module vdcm_ssm_word_dispatch #(
    parameter  int NUM_SSM = 4,
    parameter  int DATA_W  = 128,
    parameter  int DEPTH   = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    vdcm_ssm_word_dispatch_if.slave  bus,
    output logic [AW:0]              level,
    output logic                     underflow,
    output logic [31:0]              words_out
);

    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]               level_q, level_d;
    logic                      underflow_q, underflow_d;
    logic [31:0]               words_out_q, words_out_d;

    logic                      in_ready_c;
    logic                      push;
    logic [AW:0]               grant_cnt;
    logic [NUM_SSM-1:0]        ack;
    logic [NUM_SSM*DATA_W-1:0] rdata;

    // level is bounded by DEPTH (a power of 2), so its MSB is set only when full
    assign in_ready_c = ~level_q[AW] & ~flush;
    assign push       = bus.in_valid & in_ready_c;

    // Grant allocation: each requester takes the word at its rank among requesters
    always_comb begin
        logic [AW:0]   rank;
        logic [AW-1:0] addr;
        rank      = '0;
        addr      = '0;
        grant_cnt = '0;
        ack       = '0;
        rdata     = '0;
        for (int i = 0; i < NUM_SSM; i++) begin
            if (bus.rd_en[i]) begin
                if (!flush && (rank < level_q)) begin
                    addr                        = rd_ptr_q + rank[AW-1:0];
                    ack[i]                      = 1'b1;
                    rdata[i*DATA_W +: DATA_W]   = mem_q[addr];
                    grant_cnt                   = grant_cnt + (AW+1)'(1);
                end
                rank = rank + (AW+1)'(1);
            end
        end
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q + grant_cnt[AW-1:0];
        wr_ptr_d    = wr_ptr_q + AW'(push);
        level_d     = level_q + (AW+1)'(push) - grant_cnt;
        words_out_d = words_out_q + 32'(grant_cnt);
        underflow_d = |(bus.rd_en & ~ack);
        // flush wins over everything except the lifetime word counter
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            level_d     = '0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
            words_out_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
            words_out_q <= words_out_d;
        end
    end

    // Storage is never reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.rd_ack   = ack;
    assign bus.rd_data  = rdata;
    assign level        = level_q;
    assign underflow    = underflow_q;
    assign words_out    = words_out_q;

endmodule

// File: tb/tb_vdcm_ssm_word_dispatch.sv
// Bench for vdcm_ssm_word_dispatch: directed vector table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_vdcm_ssm_word_dispatch;
    localparam int NUM_SSM = 4;
    localparam int DATA_W  = 128;
    localparam int DEPTH   = 16;
    localparam int AW      = $clog2(DEPTH);

    logic              clk;
    logic              rstn;
    logic              flush;
    logic [AW:0]       lvl;
    logic              uf;
    logic [31:0]       wo;

    vdcm_ssm_word_dispatch_if #(.NUM_SSM(NUM_SSM), .DATA_W(DATA_W)) bus ();

    vdcm_ssm_word_dispatch #(.NUM_SSM(NUM_SSM), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .bus       (bus),
        .level     (lvl),
        .underflow (uf),
        .words_out (wo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "init";

    // Reference model state
    logic [DATA_W-1:0]  mq[$];
    int unsigned        m_wo;
    bit                 m_uf;
    bit                 m_rdy;
    int                 m_g;
    logic [NUM_SSM-1:0] m_ack;
    logic [DATA_W-1:0]  m_data [NUM_SSM];

    logic [NUM_SSM-1:0] last_ack;
    logic [DATA_W-1:0]  last_d [NUM_SSM];

    typedef struct packed {
        bit                 fl;
        bit                 iv;
        int                 wid;
        logic [NUM_SSM-1:0] en;
        bit                 rdy;
        logic [NUM_SSM-1:0] ack;
        int                 d0, d1, d2, d3;
        int                 lvl;
        bit                 uf;
        int                 wo;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [DATA_W-1:0] w(input int id);
        return {32'hC0DE_0000 + 32'(id), 64'h0, 32'(id)};
    endfunction

    function automatic logic [DATA_W-1:0] exp_w(input int id);
        return (id < 0) ? '0 : w(id);
    endfunction

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(bit fl, bit iv, int wid, logic [NUM_SSM-1:0] en, bit rdy,
                                logic [NUM_SSM-1:0] ack, int d0, int d1, int d2, int d3,
                                int l, bit u, int c);
        vec_t v;
        v.fl = fl; v.iv = iv; v.wid = wid; v.en = en; v.rdy = rdy; v.ack = ack;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.lvl = l; v.uf = u; v.wo = c;
        return v;
    endfunction

    // Model: the k-th requester (in index order) gets the k-th stored word
    function automatic void model_comb(input bit fl, input logic [NUM_SSM-1:0] en);
        int k;
        k     = 0;
        m_g   = 0;
        m_rdy = !fl && (mq.size() < DEPTH);
        m_ack = '0;
        for (int i = 0; i < NUM_SSM; i++) begin
            m_data[i] = '0;
            if (en[i]) begin
                if (!fl && k < mq.size()) begin
                    m_ack[i]  = 1'b1;
                    m_data[i] = mq[k];
                    m_g++;
                end
                k++;
            end
        end
    endfunction

    function automatic void model_commit(input bit fl, input bit iv, input logic [DATA_W-1:0] d,
                                         input logic [NUM_SSM-1:0] en);
        if (fl) begin
            mq.delete();
            m_uf = 1'b0;
        end else begin
            m_uf = (en & ~m_ack) != '0;
            for (int i = 0; i < m_g; i++) void'(mq.pop_front());
            if (iv && m_rdy) mq.push_back(d);
            m_wo += m_g;
        end
    endfunction

    task automatic drive(input bit fl, input bit iv, input logic [DATA_W-1:0] d,
                         input logic [NUM_SSM-1:0] en);
        flush        = fl;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.rd_en    = en;
    endtask

    // One model-checked cycle; entered and left at posedge+1
    task automatic mstep(input bit fl, input bit iv, input logic [DATA_W-1:0] d,
                         input logic [NUM_SSM-1:0] en);
        drive(fl, iv, d, en);
        model_comb(fl, en);
        @(negedge clk);
        last_ack = bus.rd_ack;
        chk($sformatf("%s.in_ready", phase), 128'(bus.in_ready), 128'(m_rdy));
        chk($sformatf("%s.rd_ack", phase), 128'(bus.rd_ack), 128'(m_ack));
        for (int i = 0; i < NUM_SSM; i++) begin
            last_d[i] = bus.rd_data[i*DATA_W +: DATA_W];
            chk($sformatf("%s.rd_data%0d", phase, i), last_d[i], m_data[i]);
        end
        @(posedge clk);
        #1;
        model_commit(fl, iv, d, en);
        chk($sformatf("%s.level", phase), 128'(lvl), 128'(mq.size()));
        chk($sformatf("%s.underflow", phase), 128'(uf), 128'(m_uf));
        chk($sformatf("%s.words_out", phase), 128'(wo), 128'(m_wo));
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            n_checks++;
            if (int'(lvl) > DEPTH) begin
                n_fail++;
                $display("FAIL level_bound: got %0d expected <= %0d", lvl, DEPTH);
            end
        end
    end

    initial begin
        vec_t        v;
        int          dd [NUM_SSM];
        logic [31:0] wo_saved;
        bit          fill, fl, iv;
        logic [NUM_SSM-1:0] en;

        m_wo = 0;
        m_uf = 1'b0;
        rstn = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        #2;
        chk("reset.level", 128'(lvl), 128'(0));
        chk("reset.underflow", 128'(uf), 128'(0));
        chk("reset.words_out", 128'(wo), 128'(0));
        chk("reset.in_ready", 128'(bus.in_ready), 128'(1));
        chk("reset.rd_ack", 128'(bus.rd_ack), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // fl iv wid en | rdy ack d0..d3 | level uf words_out
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, k, 4'b0000, 1, 4'b0000, -1, -1, -1, -1, k + 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b1111,  0,  1,  2,  3, 4, 0, 4));
        tbl.push_back(mk(0, 0, 0, 4'b1010, 1, 4'b1010, -1,  4, -1,  5, 2, 0, 6));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0011,  6,  7, -1, -1, 0, 1, 8));
        tbl.push_back(mk(0, 1, 8, 4'b1111, 1, 4'b0000, -1, -1, -1, -1, 1, 1, 8));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0001,  8, -1, -1, -1, 0, 1, 9));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0000, -1, -1, -1, -1, 0, 1, 9));
        tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, -1, -1, -1, -1, 0, 0, 9));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            dd[0] = v.d0; dd[1] = v.d1; dd[2] = v.d2; dd[3] = v.d3;
            drive(v.fl, v.iv, w(v.wid), v.en);
            model_comb(v.fl, v.en);
            @(negedge clk);
            chk($sformatf("vec%0d.in_ready", i), 128'(bus.in_ready), 128'(v.rdy));
            chk($sformatf("vec%0d.rd_ack", i), 128'(bus.rd_ack), 128'(v.ack));
            for (int s = 0; s < NUM_SSM; s++)
                chk($sformatf("vec%0d.rd_data%0d", i, s), bus.rd_data[s*DATA_W +: DATA_W], exp_w(dd[s]));
            @(posedge clk);
            #1;
            model_commit(v.fl, v.iv, w(v.wid), v.en);
            chk($sformatf("vec%0d.level", i), 128'(lvl), 128'(v.lvl));
            chk($sformatf("vec%0d.underflow", i), 128'(uf), 128'(v.uf));
            chk($sformatf("vec%0d.words_out", i), 128'(wo), 128'(v.wo));
        end

        phase = "full";
        for (int k = 0; k < DEPTH; k++) mstep(1'b0, 1'b1, w(100 + k), 4'b0000);
        chk("full.level16", 128'(lvl), 128'(16));
        mstep(1'b0, 1'b1, w(200), 4'b0001);
        chk("full.blocked_rdy", 128'(m_rdy), 128'(0));
        chk("full.grant_d0", last_d[0], w(100));
        chk("full.level15", 128'(lvl), 128'(15));
        mstep(1'b0, 1'b1, w(201), 4'b0011);
        chk("full.pushgrant_d1", last_d[1], w(102));
        chk("full.level14", 128'(lvl), 128'(14));

        phase = "wrap";
        mstep(1'b1, 1'b0, '0, 4'b0000);
        for (int k = 0; k < 14; k++) mstep(1'b0, 1'b1, w(300 + k), 4'b0000);
        for (int k = 0; k < 3; k++) mstep(1'b0, 1'b0, '0, 4'b1111);
        mstep(1'b0, 1'b0, '0, 4'b0011);
        for (int k = 0; k < 6; k++) mstep(1'b0, 1'b1, w(400 + k), 4'b0000);
        mstep(1'b0, 1'b0, '0, 4'b1111);
        chk("wrap.d0_mem14", last_d[0], w(400));
        chk("wrap.d1_mem15", last_d[1], w(401));
        chk("wrap.d2_mem0", last_d[2], w(402));
        chk("wrap.d3_mem1", last_d[3], w(403));
        chk("wrap.level", 128'(lvl), 128'(2));
        mstep(1'b0, 1'b0, '0, 4'b0001);
        chk("wrap.next_mem2", last_d[0], w(404));

        phase = "flush";
        for (int k = 0; k < 4; k++) mstep(1'b0, 1'b1, w(500 + k), 4'b0000);
        wo_saved = wo;
        mstep(1'b1, 1'b1, w(600), 4'b1111);
        chk("flush.no_ack", 128'(last_ack), 128'(0));
        chk("flush.level", 128'(lvl), 128'(0));
        chk("flush.words_out_kept", 128'(wo), 128'(wo_saved));
        mstep(1'b0, 1'b1, w(700), 4'b0000);
        mstep(1'b0, 1'b1, w(701), 4'b0001);

        phase = "areset";
        drive(1'b0, 1'b1, w(900), 4'b1111);
        #2;
        rstn = 1'b0;
        #1;
        chk("areset.level", 128'(lvl), 128'(0));
        chk("areset.words_out", 128'(wo), 128'(0));
        chk("areset.underflow", 128'(uf), 128'(0));
        chk("areset.in_ready", 128'(bus.in_ready), 128'(1));
        chk("areset.rd_ack", 128'(bus.rd_ack), 128'(0));
        drive(1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mq.delete();
        m_wo = 0;
        m_uf = 1'b0;

        phase = "rand";
        for (int c = 0; c < 600; c++) begin
            fill = ((c / 40) % 2) == 0;
            fl   = ($urandom_range(0, 49) == 0);
            iv   = fill ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            en   = NUM_SSM'($urandom);
            if (fill) en = en & NUM_SSM'($urandom);
            mstep(fl, iv, {$urandom, $urandom, $urandom, $urandom}, en);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
